// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and defaults for the data-memory arbiter
package dmem_pkg;
  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_P0   = 2'd1,
    RESP_P1   = 2'd2
  } resp_state_e;
  localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;
endpackage

// File: rtl/dmem_addr_check.sv
// dmem_addr_check: word-aligned, in-segment check of a byte address
module dmem_addr_check
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEMORY_DEPTH = 512,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR = DATA_WIDTH'(DMEM_BASE_ADDR)
) (
  input  logic [DATA_WIDTH-1:0] addr_i,
  output logic                  legal_o
);
  // One extra bit keeps the upper bound from wrapping near the top of the address space
  localparam logic [DATA_WIDTH:0] LO = {1'b0, BASE_ADDR};
  localparam logic [DATA_WIDTH:0] HI = LO + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH - 4);
  assign legal_o = (addr_i[1:0] == 2'b00) && ({1'b0, addr_i} >= LO) && ({1'b0, addr_i} <= HI);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of the data memory between CPU and DMA with a one-cycle response
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEMORY_DEPTH = 512,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR = DATA_WIDTH'(DMEM_BASE_ADDR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic [DATA_WIDTH-1:0] mem_Address,
  output logic [DATA_WIDTH-1:0] mem_WriteData,
  output logic                  mem_MemWrite,
  output logic                  mem_MemRead,
  input  logic [DATA_WIDTH-1:0] mem_ReadData
);
  logic last_gnt_q, port, any, we, legal, resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] addr, wdata, resp_data_q, resp_data_d;
  resp_state_e state_q, state_d;
  always_comb begin
    any = ~reset & (req0 | req1);
    port = (req0 & req1) ? ~last_gnt_q : req1;
    addr = (port == PORT_DMA) ? addr1 : addr0;
    wdata = (port == PORT_DMA) ? wdata1 : wdata0;
    we = (port == PORT_DMA) ? we1 : we0;
    state_d = ~any ? RESP_IDLE : (port == PORT_DMA) ? RESP_P1 : RESP_P0;
    resp_err_d = any & ~legal;
    resp_data_d = mem_MemRead ? mem_ReadData : '0;
  end
  dmem_addr_check #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .BASE_ADDR(BASE_ADDR)
  ) u_check (
    .addr_i(addr),
    .legal_o(legal)
  );
  assign gnt0 = any & (port == PORT_CPU);
  assign gnt1 = any & (port == PORT_DMA);
  assign mem_Address = any ? addr : '0;
  assign mem_WriteData = any ? wdata : '0;
  assign mem_MemWrite = any & we & legal;
  assign mem_MemRead = any & ~we & legal;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESP_IDLE;
      last_gnt_q <= PORT_DMA;
      resp_err_q <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      resp_err_q <= resp_err_d;
      resp_data_q <= resp_data_d;
      if (any) last_gnt_q <= port;
    end
  end
  // Gating with reset drops a response that is still showing when reset arrives
  assign rvalid0 = ~reset & (state_q == RESP_P0);
  assign rvalid1 = ~reset & (state_q == RESP_P1);
  assign rdata0 = rvalid0 ? resp_data_q : '0;
  assign rdata1 = rvalid1 ? resp_data_q : '0;
  assign err0 = rvalid0 & resp_err_q;
  assign err1 = rvalid1 & resp_err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench with a behavioural data memory
module tb_dmem_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_MemWrite, mem_MemRead;
  logic [31:0] rdata0, rdata1, mem_Address, mem_WriteData, mem_ReadData;
  logic [31:0] mem [512] = '{default: 32'h0};
  logic [31:0] ref_mem [512] = '{default: 32'h0};
  typedef struct packed {logic port; logic err; logic [31:0] data;} resp_t;
  resp_t q[$];
  logic m_last = 1'b1;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_Address(mem_Address), .mem_WriteData(mem_WriteData),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
    .mem_ReadData(mem_ReadData)
  );

  assign mem_ReadData = mem[mem_Address[10:2]];
  always @(posedge clk) if (mem_MemWrite) mem[mem_Address[10:2]] <= mem_WriteData;

  function automatic logic legal(input logic [31:0] a);
    return a[1:0] == 2'b00 && a >= 32'h1001_0000 && a <= 32'h1001_07FC;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic response();
    resp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rvalid0", rvalid0, e.port == 1'b0);
      chk("rvalid1", rvalid1, e.port == 1'b1);
      chk("rdata0", rdata0, e.port == 1'b0 ? e.data : 32'h0);
      chk("rdata1", rdata1, e.port == 1'b1 ? e.data : 32'h0);
      chk("err0", err0, e.port == 1'b0 && e.err);
      chk("err1", err1, e.port == 1'b1 && e.err);
    end else begin
      chk("idle_rvalid0", rvalid0, 0);
      chk("idle_rvalid1", rvalid1, 0);
    end
    chk("one_rvalid", rvalid0 & rvalid1, 0);
  endtask

  task automatic cycle(input logic r0, w0, input logic [31:0] a0, d0,
                       input logic r1, w1, input logic [31:0] a1, d1);
    logic g0, g1, g, p, we, lg;
    logic [31:0] a, d;
    resp_t e;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    g1 = (r0 && r1) ? !m_last : r1;
    g0 = r0 && !g1;
    g = g0 || g1;
    p = g1;
    a = p ? a1 : a0;
    d = p ? d1 : d0;
    we = p ? w1 : w0;
    lg = legal(a);
    chk("gnt0", gnt0, g0);
    chk("gnt1", gnt1, g1);
    chk("mem_MemWrite", mem_MemWrite, g && we && lg);
    chk("mem_MemRead", mem_MemRead, g && !we && lg);
    chk("mem_Address", mem_Address, g ? a : 32'h0);
    if (g) begin
      e.port = p;
      e.err = !lg;
      e.data = (!we && lg) ? ref_mem[a[10:2]] : 32'h0;
      q.push_back(e);
      if (we && lg) ref_mem[a[10:2]] = d;
      m_last = p;
    end
    @(posedge clk); #1;
    response();
  endtask

  initial begin
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_memread", mem_MemRead, 0);
    chk("rst_rvalid0", rvalid0, 0);
    @(posedge clk); #1;
    chk("rst_rvalid1", rvalid1, 0);
    reset = 1'b0;
    // Write then immediate read-back on the CPU port
    cycle(1, 1, 32'h1001_0004, 32'hDEAD_BEEF, 0, 0, 0, 0);
    cycle(1, 0, 32'h1001_0004, 0, 0, 0, 0, 0);
    chk("wr_rd_data", rdata0, 32'hDEAD_BEEF);
    cycle(1, 1, 32'h1001_0000, 32'hA5A5_A5A5, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1, 32'h1001_0008, 32'h1234_5678);
    // Both ports contending: grants alternate starting with port 0
    for (int i = 0; i < 4; i++) cycle(1, 0, 32'h1001_0000, 0, 1, 0, 32'h1001_0008, 0);
    chk("alt_last_rdata1", rdata1, 32'h1234_5678);
    cycle(0, 0, 0, 0, 1, 1, 32'h1001_0802, 32'hBAD0_BAD0);
    cycle(0, 0, 0, 0, 1, 1, 32'h1001_0800, 32'hBAD1_BAD1);
    chk("past_end_err1", err1, 1);
    cycle(0, 0, 0, 0, 1, 1, 32'h1001_0006, 32'hBAD2_BAD2);
    cycle(0, 0, 0, 0, 1, 0, 32'h1001_0000, 0);
    chk("unchanged_w0", rdata1, 32'hA5A5_A5A5);
    cycle(0, 0, 0, 0, 1, 0, 32'h1001_0004, 0);
    chk("unchanged_w1", rdata1, 32'hDEAD_BEEF);
    cycle(0, 0, 0, 0, 1, 0, 32'h1000_FFFC, 0);
    chk("below_base_err1", err1, 1);
    cycle(1, 1, 32'h1001_07FC, 32'h1357_9BDF, 0, 0, 0, 0);
    cycle(1, 0, 32'h1001_07FC, 0, 0, 0, 0, 0);
    chk("last_word", rdata0, 32'h1357_9BDF);
    // Port 1 alone, then port 0 joins and wins because port 1 went last
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0, 32'h1001_0008, 0);
    cycle(1, 0, 32'h1001_0000, 0, 1, 0, 32'h1001_0008, 0);
    chk("join_rdata0", rdata0, 32'hA5A5_A5A5);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    // Grant in N, reset in N+1 drops the response
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h1001_0000; req1 = 1'b0;
    #1;
    chk("pre_rst_gnt0", gnt0, 1);
    @(posedge clk);
    reset = 1'b1; req1 = 1'b1; addr1 = 32'h1001_0008; we1 = 1'b0;
    #1;
    chk("drop_rvalid0", rvalid0, 0);
    chk("rst_gnt0_b", gnt0, 0);
    chk("rst_gnt1_b", gnt1, 0);
    chk("rst_strobe", mem_MemRead | mem_MemWrite, 0);
    @(posedge clk); #1;
    chk("rst_rvalid0_b", rvalid0, 0);
    reset = 1'b0;
    m_last = 1'b1;
    cycle(1, 0, 32'h1001_0000, 0, 1, 0, 32'h1001_0008, 0);
    chk("post_rst_tie", rvalid0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
